// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 game: direction codes, game-state codes,
// the input-controller FSM encoding and the button priority encoder.
package game2048_pkg;

    // One-hot move codes presented to the game core
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    // Game-state codes driven by the core
    localparam logic [1:0] GS_IDLE    = 2'b00;
    localparam logic [1:0] GS_PLAYING = 2'b01;
    localparam logic [1:0] GS_WIN     = 2'b10;
    localparam logic [1:0] GS_LOSE    = 2'b11;

    // Input controller FSM states
    typedef enum logic [1:0] {
        IN_IDLE    = 2'd0,
        IN_HOLD    = 2'd1,
        IN_RELEASE = 2'd2
    } in_state_t;

    // Lowest set press bit wins: up > down > left > right
    function automatic logic [3:0] dir_from_press(input logic [3:0] press);
        logic [3:0] dir;
        dir = DIR_NONE;
        if (press[0])      dir = DIR_UP;
        else if (press[1]) dir = DIR_DOWN;
        else if (press[2]) dir = DIR_LEFT;
        else if (press[3]) dir = DIR_RIGHT;
        return dir;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: two-flop synchroniser, counter-based debounce
// and rising-edge detect on the debounced level.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous raw button input
//   level - debounced pressed level, active-high (registered)
//   press - one-cycle pulse on the debounced press edge
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic        RELEASED = BTN_ACTIVE_LOW;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_p;

    // Synchroniser; stages preset to the released level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RELEASED;
            r_sync2 <= RELEASED;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // Accept a new level only after it persists DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            if (w_p == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= w_p;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_stable;
    assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/direction_input_ctrl.sv
// Button front-end for the 2048 core: conditions four buttons and issues one
// one-hot move per physical press, held for HOLD_CYCLES, re-arming only after
// every button has been released.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   btn_raw   - raw buttons, bit0 up, bit1 down, bit2 left, bit3 right
//   enable    - 1 = accept new presses
//   direction - one-hot move to the core, 0000 = none (registered)
//   btn_level - debounced pressed levels, active-high (registered)
//   busy      - 1 while in HOLD or RELEASE (registered)
module direction_input_ctrl
    import game2048_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       enable,
    output logic [3:0] direction,
    output logic [3:0] btn_level,
    output logic       busy
);

    localparam int unsigned HOLD_W       = $clog2(HOLD_CYCLES + 1);
    // Longer than sync + debounce latency, so a button held across reset is
    // always seen before the block arms.
    localparam int unsigned QUIET_CYCLES = DEBOUNCE_CYCLES + 3;
    localparam int unsigned QUIET_W      = $clog2(QUIET_CYCLES + 1);

    in_state_t         r_state;
    in_state_t         w_state_nxt;
    logic [3:0]        r_dir;
    logic [3:0]        w_dir_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_busy;
    logic              r_armed;
    logic [QUIET_W-1:0] r_quiet_cnt;
    logic [3:0]        w_level;
    logic [3:0]        w_press;

    // Per-button conditioning
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[gi]),
            .level (w_level[gi]),
            .press (w_press[gi])
        );
    end

    // After reset, wait for an all-released quiet window before accepting presses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_quiet_cnt <= '0;
        end else if (!r_armed) begin
            if (w_level != 4'b0000) begin
                r_quiet_cnt <= '0;
            end else if (r_quiet_cnt == QUIET_W'(QUIET_CYCLES - 1)) begin
                r_armed     <= 1'b1;
                r_quiet_cnt <= '0;
            end else begin
                r_quiet_cnt <= r_quiet_cnt + QUIET_W'(1);
            end
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IN_IDLE;
            r_dir      <= DIR_NONE;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_busy     <= (w_state_nxt != IN_IDLE);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            IN_IDLE: begin
                w_dir_nxt = DIR_NONE;
                if (enable && r_armed && (|w_press)) begin
                    w_dir_nxt   = dir_from_press(w_press);
                    w_hold_nxt  = '0;
                    w_state_nxt = IN_HOLD;
                end
            end
            IN_HOLD: begin
                if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_dir_nxt   = DIR_NONE;
                    w_state_nxt = IN_RELEASE;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            IN_RELEASE: begin
                // New presses here are ignored; only full release re-arms
                w_dir_nxt = DIR_NONE;
                if (w_level == 4'b0000) begin
                    w_state_nxt = IN_IDLE;
                end
            end
            default: begin
                w_dir_nxt   = DIR_NONE;
                w_state_nxt = IN_IDLE;
            end
        endcase
    end

    assign direction = r_dir;
    assign btn_level = w_level;
    assign busy      = r_busy;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed bench for direction_input_ctrl with a move scoreboard.
module tb_direction_input_ctrl;

    localparam logic [3:0] D_UP    = 4'b0001;
    localparam logic [3:0] D_DOWN  = 4'b0010;
    localparam logic [3:0] D_LEFT  = 4'b0100;
    localparam logic [3:0] D_RIGHT = 4'b1000;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic       enable;
    logic [3:0] direction;
    logic [3:0] btn_level;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] dir;
        int         len;
    } move_t;

    move_t      exp_q[$];
    logic [3:0] run_dir = 4'b0000;
    int         run_len = 0;

    direction_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (4),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .enable    (enable),
        .direction (direction),
        .btn_level (btn_level),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_move(input logic [3:0] d, input int len);
        move_t m;
        m.dir = d;
        m.len = len;
        exp_q.push_back(m);
    endtask

    // Move monitor: each non-zero pulse must be one-hot, constant, and match the queue head
    always @(negedge clk) begin
        move_t m;
        if (direction !== 4'b0000) begin
            chk("onehot", 32'($onehot(direction)), 32'd1);
            if (run_len == 0) run_dir = direction;
            else chk("dir_steady", 32'(direction), 32'(run_dir));
            run_len++;
        end else if (run_len != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_move", 32'(run_dir), 32'd0);
            end else begin
                m = exp_q.pop_front();
                chk("move_dir", 32'(run_dir), 32'(m.dir));
                chk("move_len", 32'(run_len), 32'(m.len));
            end
            run_len = 0;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        btn_raw = 4'hF;
        enable  = 1'b1;
        cyc(3);
        chk("rst_dir", 32'(direction), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        cyc(12);

        // Clean press of down
        btn_raw = 4'b1101;
        push_move(D_DOWN, 4);
        cyc(6);
        chk("clean_edge6_dir", 32'(direction), 32'd0);
        chk("clean_edge6_level", 32'(btn_level), 32'(4'b0010));
        cyc(1);
        chk("clean_edge7_dir", 32'(direction), 32'(D_DOWN));
        chk("clean_edge7_busy", 32'(busy), 32'd1);
        cyc(3);
        chk("clean_edge10_dir", 32'(direction), 32'(D_DOWN));
        cyc(1);
        chk("clean_edge11_dir", 32'(direction), 32'd0);
        cyc(10);
        chk("clean_held_busy", 32'(busy), 32'd1);
        btn_raw = 4'hF;
        cyc(6);
        chk("clean_rel6_busy", 32'(busy), 32'd1);
        chk("clean_rel6_level", 32'(btn_level), 32'd0);
        cyc(1);
        chk("clean_rel7_busy", 32'(busy), 32'd0);
        cyc(5);

        // Bounce: pulses of 3 cycles are shorter than the debounce window
        btn_raw = 4'b1110; cyc(3);
        chk("bounce_a_level", 32'(btn_level), 32'd0);
        btn_raw = 4'hF;    cyc(2);
        btn_raw = 4'b1110; cyc(3);
        btn_raw = 4'hF;    cyc(10);
        chk("bounce_level", 32'(btn_level), 32'd0);
        chk("bounce_busy", 32'(busy), 32'd0);
        chk("bounce_dir", 32'(direction), 32'd0);

        // Simultaneous left + right: left wins, right never fires
        btn_raw = 4'b0011;
        push_move(D_LEFT, 4);
        cyc(7);
        chk("simul_dir", 32'(direction), 32'(D_LEFT));
        chk("simul_level", 32'(btn_level), 32'(4'b1100));
        cyc(10);
        btn_raw = 4'b0111;
        cyc(10);
        chk("simul_right_level", 32'(btn_level), 32'(4'b1000));
        chk("simul_right_busy", 32'(busy), 32'd1);
        chk("simul_right_dir", 32'(direction), 32'd0);
        btn_raw = 4'hF;
        cyc(7);
        chk("simul_rel_busy", 32'(busy), 32'd0);
        cyc(3);

        // Gating: press while disabled is dropped, not queued
        enable  = 1'b0;
        btn_raw = 4'b0111;
        cyc(8);
        chk("gate_dir", 32'(direction), 32'd0);
        chk("gate_busy", 32'(busy), 32'd0);
        chk("gate_level", 32'(btn_level), 32'(4'b1000));
        enable = 1'b1;
        cyc(10);
        chk("gate_en_dir", 32'(direction), 32'd0);
        chk("gate_en_busy", 32'(busy), 32'd0);
        btn_raw = 4'hF;
        cyc(8);
        btn_raw = 4'b0111;
        push_move(D_RIGHT, 4);
        cyc(7);
        chk("gate_repress_dir", 32'(direction), 32'(D_RIGHT));
        cyc(5);
        btn_raw = 4'hF;
        cyc(8);
        chk("gate_rel_busy", 32'(busy), 32'd0);

        // Long hold of up, with down pressed during RELEASE
        btn_raw = 4'b1110;
        push_move(D_UP, 4);
        cyc(7);
        chk("hold_dir", 32'(direction), 32'(D_UP));
        cyc(10);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_dir_off", 32'(direction), 32'd0);
        btn_raw = 4'b1100;
        cyc(20);
        chk("hold_down_level", 32'(btn_level), 32'(4'b0011));
        chk("hold_down_dir", 32'(direction), 32'd0);
        cyc(63);
        btn_raw = 4'hF;
        cyc(8);
        chk("hold_rel_busy", 32'(busy), 32'd0);
        chk("hold_rel_level", 32'(btn_level), 32'd0);

        // Reset during the second HOLD cycle with the button still held
        btn_raw = 4'b1110;
        push_move(D_UP, 2);
        cyc(8);
        chk("rsthold_pre_dir", 32'(direction), 32'(D_UP));
        rst = 1'b1;
        cyc(1);
        chk("rsthold_dir", 32'(direction), 32'd0);
        chk("rsthold_busy", 32'(busy), 32'd0);
        chk("rsthold_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        cyc(30);
        chk("rsthold_held_dir", 32'(direction), 32'd0);
        chk("rsthold_held_busy", 32'(busy), 32'd0);
        chk("rsthold_held_level", 32'(btn_level), 32'(4'b0001));
        btn_raw = 4'hF;
        cyc(16);
        btn_raw = 4'b1110;
        push_move(D_UP, 4);
        cyc(7);
        chk("rsthold_repress_dir", 32'(direction), 32'(D_UP));
        cyc(5);
        btn_raw = 4'hF;
        cyc(10);
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_no_open_pulse", 32'(run_len), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
